// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen
//   Serial pattern transmitter. On an accepted start the WIDTH-bit pattern is
//   shifted out MSB-first, one bit per clock, repeated back-to-back repeat_n
//   times, followed by a one-cycle done pulse. Every output is registered.
//
// Ports
//   clk       clock, all logic on the rising edge
//   rst       synchronous active-high reset, highest priority
//   start     transfer request, only looked at while idle
//   pattern   WIDTH-bit pattern, captured on an accepted start
//   repeat_n  number of pattern copies, captured on an accepted start
//   out       serial data bit, 0 whenever valid is low
//   valid     out carries a pattern bit this cycle
//   busy      high in every state except IDLE
//   done      one-cycle pulse in the cycle after the final bit
module seq_pattern_gen #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] pat_q, pat_q_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [CNT_W-1:0] rep_cnt, rep_cnt_n;
  logic             out_n, valid_n, busy_n, done_n;

  // The MSB of shreg is always the bit being presented on out in the current
  // cycle, so the registered out for the next cycle is whatever lands in the
  // MSB after this edge's load, shift or reload.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    pat_q_n   = pat_q;
    bit_cnt_n = bit_cnt;
    rep_cnt_n = rep_cnt;
    out_n     = 1'b0;
    valid_n   = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          busy_n = 1'b1;
          if (repeat_n != '0) begin
            state_n   = SEND;
            pat_q_n   = pattern;
            shreg_n   = pattern;
            rep_cnt_n = repeat_n;
            bit_cnt_n = '0;
            out_n     = pattern[WIDTH-1];
            valid_n   = 1'b1;
          end else begin
            // Zero copies: skip straight to the done pulse.
            state_n = DONE;
            done_n  = 1'b1;
          end
        end
      end

      SEND: begin
        busy_n = 1'b1;
        if (bit_cnt == LAST) begin
          if (rep_cnt > CNT_W'(1)) begin
            // Reload for the next copy with no gap between copies.
            shreg_n   = pat_q;
            out_n     = pat_q[WIDTH-1];
            valid_n   = 1'b1;
            rep_cnt_n = rep_cnt - CNT_W'(1);
            bit_cnt_n = '0;
          end else begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end else begin
          shreg_n   = {shreg[WIDTH-2:0], 1'b0};
          out_n     = shreg[WIDTH-2];
          valid_n   = 1'b1;
          bit_cnt_n = bit_cnt + BW'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      pat_q   <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      out     <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      pat_q   <= pat_q_n;
      bit_cnt <= bit_cnt_n;
      rep_cnt <= rep_cnt_n;
      out     <= out_n;
      valid   <= valid_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial pattern transmitter: the generating end of the bit-serial sequence-detector interface. On a start request it loads a WIDTH-bit pattern and shifts it out MSB-first, one bit per clk, repeating it back-to-back a programmable number of times. Its `out` drives the `in` of a sequence detector (e.g. the 1001 Mealy detector), both as a stimulus source in benches and as an on-chip pattern source.

## Interface
- `WIDTH`, 4: pattern length in bits, ≥2.
- `CNT_W`, 4: width of the repeat count.
- `clk`  input  1  clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE.
- `pattern`  input  WIDTH  pattern to send, MSB first; captured on accepted start (default use 4'b1001).
- `repeat_n`  input  CNT_W  number of back-to-back pattern copies; captured on accepted start.
- `out`  output  1  serial data bit; 0 whenever `valid`=0.
- `valid`  output  1  `out` carries a pattern bit this cycle.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse after the final bit.

## Operation
- Registers: `shreg[WIDTH-1:0]`, `pat_q[WIDTH-1:0]`, `bit_cnt` (0..WIDTH-1), `rep_cnt[CNT_W-1:0]`, and a state register. All outputs are registered.
- States: IDLE, SEND, DONE.
- IDLE:
  - `start`=1 and `repeat_n`≠0: set `pat_q`=`shreg`=`pattern`, `rep_cnt`=`repeat_n`, `bit_cnt`=0, go to SEND.
  - `start`=1 and `repeat_n`=0: go directly to DONE. No bits are sent.
  - `start`=0: stay in IDLE.
- SEND:
  - Each cycle: `out`=`shreg[WIDTH-1]`, `valid`=1, shift `shreg` left (shift in 0), increment `bit_cnt`.
  - When `bit_cnt`=WIDTH-1 and `rep_cnt`>1: reload `shreg` from `pat_q`, decrement `rep_cnt`, clear `bit_cnt`. The next pattern copy follows with no gap.
  - When `bit_cnt`=WIDTH-1 and `rep_cnt`=1: go to DONE.
- DONE: `done`=1 and `valid`=0 for one cycle, then go to IDLE.
- `start` in SEND or DONE is ignored. It is not queued.
- `pattern` and `repeat_n` may change freely after capture without affecting the transfer in progress.
- Stream length: exactly WIDTH×`repeat_n` bits. `rep_cnt` never wraps; at the maximum `repeat_n`=2^CNT_W−1 the block sends that many copies.

## Timing
- Reset values (`rst`=1 at an edge): state=IDLE, `out`=0, `valid`=0, `busy`=0, `done`=0, all counters and shift registers 0.
- Reset has priority over every other input. Reset during SEND or DONE aborts at once: next cycle `valid`=0 and no `done` pulse.
- Cycle numbering: `start` is accepted at edge k.
  - First bit on `out` with `valid`=1 during cycle k+1 (after edge k).
  - Last bit during cycle k+WIDTH×`repeat_n`.
  - `done`=1 during the following cycle.
  - `busy` is high from cycle k+1 through the `done` cycle inclusive.
- `repeat_n`=0: `done` and `busy` are high during cycle k+1 only.
- `start` held high continuously: the next transfer is accepted at the first edge in IDLE. This gives exactly one idle cycle (`busy`=0) between the `done` cycle and the next first bit.
- Downstream detector: it samples `out` on the same rising edge that advances the bit. Bit i is therefore sampled at edge k+i+1.

## Test plan
- Single copy:
  - Stimulus: `pattern`=1001, `repeat_n`=1, start pulse at edge 0.
  - Required: cycles 1–4 give `out`=1,0,0,1 with `valid`=1; cycle 5 gives `done`=1; cycle 6 gives `busy`=0.
  - Loopback: a 1001 detector attached to `out` flags exactly one detection.
- Two copies:
  - Stimulus: `pattern`=1001, `repeat_n`=2.
  - Required: `out`=1,0,0,1,1,0,0,1 in cycles 1–8 with no gap; `done` in cycle 9; the detector flags 2 detections.
- Zero repeats:
  - Stimulus: `repeat_n`=0, start pulse.
  - Required: `valid` never asserts; `done`=`busy`=1 in cycle 1 only.
- Start while busy:
  - Stimulus: start accepted with `pattern`=1001, `repeat_n`=3; `start` pulsed again and `pattern` changed to 0110 during cycle 5.
  - Required: the stream is 12 bits of 1001 repeated; a single `done` in cycle 13; no second transfer begins.
- Reset mid-stream:
  - Stimulus: `rst`=1 at edge 3 of a `repeat_n`=2 transfer.
  - Required: from cycle 4, `out`=`valid`=`busy`=`done`=0; a fresh start then yields a full correct stream.
- Continuous start:
  - Stimulus: `start` held at 1 with `pattern`=1011, `repeat_n`=1.
  - Required: bits in cycles 1–4, `done` in cycle 5, idle in cycle 6, next bits in cycles 7–10.
